sum_bcd_display: RTL
====================

Name: sum_bcd_display

Overview:
- Downstream consumer of the 4-bit ripple adder's 5-bit sum.
- On a start strobe it captures the sum and converts it to two BCD digits using a sequential double-dabble (shift-add-3) algorithm, one bit per cycle.
- It then drives two 7-segment digit outputs for the lab board, with a busy/done handshake toward the controlling logic.

Parameters:
- SEG_ACTIVE_LOW, 1: 1 = segment lit by driving 0 (board default); 0 = every segment bit inverted.
- BLANK_LEADING_ZERO, 1: 1 = tens display blank when tens digit is 0; 0 = shows "0".

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- sum  input  5  unsigned adder result, 0..31.
- start  input  1  request conversion; sampled only in IDLE.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse, digits/segments just updated.
- tens  output  4  BCD tens digit, 0..3.
- units  output  4  BCD units digit, 0..9.
- seg_tens  output  7  tens segments, bit6=g .. bit0=a.
- seg_units  output  7  units segments, bit6=g .. bit0=a.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset dominates all other inputs; same effect mid-conversion. Reset values:
  - state=IDLE, busy=0, done=0, tens=0, units=0.
  - seg_units = "0" (7'h40 active-low).
  - seg_tens = blank (7'h7F) if BLANK_LEADING_ZERO, else 7'h40.
  - Internal shift register and counter cleared.
- FSM IDLE -> SHIFT -> DONE -> IDLE:
  - IDLE: start=1 at edge E0 latches sum into a 5-bit shift register, clears the 8-bit BCD accumulator and the 3-bit counter, and moves to SHIFT. start=0: stay.
  - SHIFT: each edge E1..E5 first adds 3 to any BCD nibble >= 5, then shifts {bcd, sreg} left by 1 and increments the counter. At E5 (counter==4): register tens/units from the final accumulator, update both segment outputs, go to DONE.
  - DONE: done=1 for exactly one cycle (between E5 and E6); E6 returns to IDLE.
- Latency: start sampled at E0 -> done high after E5 -> outputs valid from E5. Minimum start-to-start period is 7 edges; start held high back-to-back is accepted at E0, E7, E14, ...
- start in SHIFT/DONE is ignored and not queued.
- sum is sampled only at E0; changes during conversion do not affect the result.
- tens/units/seg outputs hold their last value until the next E5 or reset. They never show intermediate values.
- Segment encoding, active-low (gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - Codes 10..15 (unreachable) -> 7F.
  - SEG_ACTIVE_LOW=0 outputs the bitwise inverse.
- Blanking: if BLANK_LEADING_ZERO=1 and tens==0, seg_tens=blank (7F active-low, 00 active-high). tens itself still reads 0.
- Range: full 5-bit input 0..31 converts correctly (31 -> 3,1). No overflow possible.

Test Plan:
- Reset: assert rst 2 cycles -> busy=0, done=0, tens=0, units=0, seg_units=7'h40, seg_tens=7'h7F.
- sum=0, start pulse at E0 -> busy high E0..E6, done high only between E5 and E6; tens=0, units=0, seg_tens=7'h7F, seg_units=7'h40.
- sum=30 (15+15 from adder) -> tens=3, units=0, seg_tens=7'h30, seg_units=7'h40. sum=31 -> 3, 1, 7'h30, 7'h79.
- sum=19 at E0; change sum to 7 at E2 and pulse start at E3 -> result tens=1, units=9 (seg 7'h79, 7'h10). Exactly one done pulse, no second conversion.
- start at E0 with sum=25, rst=1 at E3 -> after E3: IDLE, busy=0; done never asserts; outputs equal reset values. Next start with sum=25 -> 2, 5.
- start held high, sum swept 0..31 once per accepted conversion (every 7 edges) -> each done pulse has tens=sum/10, units=sum%10, segments per table. Repeat with SEG_ACTIVE_LOW=0, BLANK_LEADING_ZERO=0 -> inverted codes, sum<10 gives seg_tens=~7'h40.

Source files
------------

// File: rtl/sum_bcd_display.sv
// sum_bcd_display: converts a 5-bit adder sum to two BCD digits
// by serial double-dabble and drives two 7-segment digits.
module sum_bcd_display #(
  parameter bit SEG_ACTIVE_LOW     = 1'b1,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_units
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  state_t      state;
  logic [4:0]  sreg;
  logic [7:0]  bcd;
  logic [2:0]  cnt;

  logic [7:0]  adj;
  logic [12:0] shl;
  logic [7:0]  bcd_nxt;
  logic [4:0]  sreg_nxt;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    return SEG_ACTIVE_LOW ? c : ~c;
  endfunction

  function automatic logic [6:0] tens_enc(input logic [3:0] d);
    if (BLANK_LEADING_ZERO && d == 4'd0)
      return SEG_BLANK;
    return seg_enc(d);
  endfunction

  // One double-dabble step: add 3 to nibbles >= 5, then shift left.
  always_comb begin
    adj = bcd;
    if (bcd[3:0] >= 4'd5)
      adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5)
      adj[7:4] = bcd[7:4] + 4'd3;
    shl      = {adj, sreg} << 1;
    bcd_nxt  = shl[12:5];
    sreg_nxt = shl[4:0];
  end

  // Conversion FSM with registered handshake and display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      bcd       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tens      <= '0;
      units     <= '0;
      seg_tens  <= tens_enc(4'd0);
      seg_units <= seg_enc(4'd0);
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sreg  <= sum;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd  <= bcd_nxt;
          sreg <= sreg_nxt;
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd4) begin
            tens      <= bcd_nxt[7:4];
            units     <= bcd_nxt[3:0];
            seg_tens  <= tens_enc(bcd_nxt[7:4]);
            seg_units <= seg_enc(bcd_nxt[3:0]);
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
